// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, constants and fault check for the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
    localparam int DMEM_WORD_BYTES = 4;
    localparam int DMEM_ADDR_LSB = 2;
    function automatic logic dmem_fault(input logic [31:0] addr, input int unsigned depth);
        return addr[DMEM_ADDR_LSB-1:0] != '0 || 32'(addr[31:DMEM_ADDR_LSB]) >= depth;
    endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake between the MEM stage and the data memory.
interface dmem_responder_if;
    logic req_valid, req_write, req_ready, resp_valid, resp_err, busy;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input req_ready, resp_valid, resp_rdata, resp_err, busy
    );
    modport slave (
        input req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM, synchronous write, registered read, contents survive reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    always_ff @(posedge clock) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with programmable wait states.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic clock,
    input logic reset,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
    dmem_state_t state, state_next;
    logic [3:0] cnt;
    logic cap_write, err, load_ok, accept, commit, op_write, op_fault;
    logic [31:0] cap_addr, cap_wdata, op_addr, op_wdata, rdata;
    // With zero wait states the access happens on the accepting edge, so use the live request.
    assign accept = state == IDLE && bus.req_valid;
    assign op_write = state == IDLE ? bus.req_write : cap_write;
    assign op_addr = state == IDLE ? bus.req_addr : cap_addr;
    assign op_wdata = state == IDLE ? bus.req_wdata : cap_wdata;
    assign op_fault = dmem_fault(op_addr, DEPTH_WORDS);
    assign commit = state_next == RESP && state != RESP;
    always_comb begin
        state_next = state == IDLE ? (bus.req_valid ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE)
                   : state == WAIT ? (cnt == '0 ? RESP : WAIT)
                   : IDLE;
        bus.req_ready = state == IDLE;
        bus.busy = state != IDLE;
        bus.resp_valid = state == RESP;
        bus.resp_err = state == RESP && err;
        bus.resp_rdata = state == RESP && load_ok ? rdata : '0;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            cap_write <= 1'b0;
            cap_addr <= '0;
            cap_wdata <= '0;
            err <= 1'b0;
            load_ok <= 1'b0;
        end else begin
            state <= state_next;
            cnt <= accept ? CNT_INIT : (state == WAIT && cnt != '0) ? cnt - 4'd1 : cnt;
            if (accept) begin
                cap_write <= bus.req_write;
                cap_addr <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
            end
            if (commit) begin
                err <= op_fault;
                load_ok <= !op_write && !op_fault;
            end
        end
    end
    // Gating the write with reset lets a reset on the committing edge leave the word intact.
    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clock(clock),
        .we(commit && op_write && !op_fault && reset),
        .re(commit && !op_write && !op_fault),
        .addr(op_addr[AW+DMEM_ADDR_LSB-1:DMEM_ADDR_LSB]),
        .wdata(op_wdata),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (2, 0 and 1 wait states) checked against a transaction-level model.
module tb_dmem_responder;
    logic clock = 0;
    always #5 clock = ~clock;
    int checks = 0, failures = 0, edges = 0;
    always @(posedge clock) edges++;
    logic rst_n [3];
    logic req_valid [3], req_write [3];
    logic [31:0] req_addr [3], req_wdata [3];
    wire req_ready [3], resp_valid [3], resp_err [3], busy [3];
    wire [31:0] resp_rdata [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : m
        localparam int W = g == 0 ? 2 : g == 1 ? 0 : 1;
        dmem_responder_if bus ();
        dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) dut (
            .clock(clock), .reset(rst_n[g]), .bus(bus.slave)
        );
        assign bus.req_valid = req_valid[g];
        assign bus.req_write = req_write[g];
        assign bus.req_addr = req_addr[g];
        assign bus.req_wdata = req_wdata[g];
        assign req_ready[g] = bus.req_ready;
        assign resp_valid[g] = bus.resp_valid;
        assign resp_err[g] = bus.resp_err;
        assign busy[g] = bus.busy;
        assign resp_rdata[g] = bus.resp_rdata;

        // Model: a transaction accepted at edge a owns the responder until edge a+W+1,
        // its response shows in the cycle after edge a+W.
        int n = 0, acc = 0, re = 0;
        bit pend = 0, mw = 0, me = 0, known = 0;
        logic [31:0] ma = 0, md = 0, er = 0;
        logic [31:0] mem [int];
        always @(posedge clock) begin
            n++;
            if (!rst_n[g]) pend = 0;
            else begin
                if (!pend && req_valid[g]) begin
                    pend = 1; acc = n; re = n + W;
                    mw = req_write[g]; ma = req_addr[g]; md = req_wdata[g];
                    me = ma % 4 != 0 || ma / 4 >= 256;
                end else if (pend && n == re + 1) pend = 0;
                if (pend && n == re) begin
                    er = 0; known = 1;
                    if (!me && mw) mem[int'(ma / 4)] = md;
                    else if (!me) begin
                        known = mem.exists(int'(ma / 4)) != 0;
                        if (known) er = mem[int'(ma / 4)];
                    end
                end
            end
        end

        always @(negedge clock) begin
            if (!rst_n[g]) begin
                chkb($sformatf("d%0d_rst_ready", g), req_ready[g], 1'b1);
                chkb($sformatf("d%0d_rst_busy", g), busy[g], 1'b0);
                chkb($sformatf("d%0d_rst_valid", g), resp_valid[g], 1'b0);
                chkb($sformatf("d%0d_rst_err", g), resp_err[g], 1'b0);
                chk($sformatf("d%0d_rst_rdata", g), resp_rdata[g], 32'h0);
            end else begin
                chkb($sformatf("d%0d_ready", g), req_ready[g], !pend);
                chkb($sformatf("d%0d_busy", g), busy[g], pend);
                chkb($sformatf("d%0d_valid", g), resp_valid[g], pend && n == re);
                if (pend && n == re) begin
                    chkb($sformatf("d%0d_err", g), resp_err[g], me);
                    if (mw || me) chk($sformatf("d%0d_rdata0", g), resp_rdata[g], 32'h0);
                    else if (known) chk($sformatf("d%0d_rdata", g), resp_rdata[g], er);
                end
            end
        end
    end

    // All stimulus tasks are entered and left on a falling edge.
    task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd, output int at);
        req_valid[d] = 1; req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd;
        for (int i = 0; i < 50 && !req_ready[d]; i++) @(negedge clock);
        if (!req_ready[d]) begin
            checks++; failures++;
            $display("FAIL accept_timeout d%0d: req_ready stayed 0, required 1", d);
        end
        @(negedge clock);
        at = edges;
        req_valid[d] = 0;
    endtask

    task automatic wait_resp(input int d, output int at, output logic [31:0] rd, output logic er);
        at = -1; rd = 0; er = 0;
        for (int i = 0; i < 50; i++) begin
            if (resp_valid[d]) begin
                at = edges; rd = resp_rdata[d]; er = resp_err[d];
                break;
            end
            @(negedge clock);
        end
        if (at < 0) begin
            checks++; failures++;
            $display("FAIL resp_timeout d%0d: resp_valid stayed 0, required 1", d);
        end
    endtask

    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
        int a0, a1;
        issue(d, w, a, wd, a0);
        wait_resp(d, a1, rd, er);
        lat = a1 - a0;
    endtask

    initial begin
        int at, lat, lows, k, nb, bb, nv;
        int ea [3];
        logic [31:0] rd;
        logic er, go;
        logic [31:0] bdat [3];
        bdat[0] = 32'hA0A0A0A0; bdat[1] = 32'hB1B1B1B1; bdat[2] = 32'hC2C2C2C2;
        ea[0] = 0; ea[1] = 0; ea[2] = 0;
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 0; req_valid[d] = 0; req_write[d] = 0; req_addr[d] = 0; req_wdata[d] = 0;
        end
        repeat (2) @(negedge clock);
        chkb("reset_ready", req_ready[0], 1'b1);
        chkb("reset_busy", busy[0], 1'b0);
        chkb("reset_valid", resp_valid[0], 1'b0);
        chk("reset_rdata", resp_rdata[0], 32'h0);
        #2 for (int d = 0; d < 3; d++) rst_n[d] = 1;
        @(negedge clock);

        xfer(0, 1, 32'h10, 32'hDEADBEEF, lat, rd, er);
        chk("w2_store_lat", lat, 2);
        chk("w2_store_rdata", rd, 32'h0);
        chkb("w2_store_err", er, 1'b0);
        xfer(0, 0, 32'h10, 32'h0, lat, rd, er);
        chk("w2_load_lat", lat, 2);
        chk("w2_load_rdata", rd, 32'hDEADBEEF);
        chkb("w2_load_err", er, 1'b0);

        xfer(0, 1, 32'h12, 32'hAAAA5555, lat, rd, er);
        chkb("misaligned_store_err", er, 1'b1);
        xfer(0, 0, 32'h10, 32'h0, lat, rd, er);
        chk("misaligned_no_write", rd, 32'hDEADBEEF);
        xfer(0, 0, 32'h400, 32'h0, lat, rd, er);
        chkb("range_load_err", er, 1'b1);
        chk("range_load_rdata", rd, 32'h0);

        xfer(0, 1, 32'h34, 32'h0, lat, rd, er);
        issue(0, 1, 32'h30, 32'h55AA00FF, at);
        req_addr[0] = 32'h34; req_wdata[0] = 32'hFFFFFFFF;
        @(negedge clock);
        req_addr[0] = 32'h38; req_wdata[0] = 32'h0BADF00D;
        wait_resp(0, at, rd, er);
        xfer(0, 0, 32'h30, 32'h0, lat, rd, er);
        chk("ignored_captured", rd, 32'h55AA00FF);
        xfer(0, 0, 32'h34, 32'h0, lat, rd, er);
        chk("ignored_untouched", rd, 32'h0);

        xfer(0, 1, 32'h20, 32'h22222222, lat, rd, er);
        issue(0, 1, 32'h20, 32'h11111111, at);
        #2 rst_n[0] = 0;
        nv = 0;
        repeat (3) begin
            @(negedge clock);
            if (resp_valid[0]) nv++;
        end
        chk("midreset_no_resp", nv, 0);
        chkb("midreset_busy", busy[0], 1'b0);
        #2 rst_n[0] = 1;
        @(negedge clock);
        xfer(0, 0, 32'h20, 32'h0, lat, rd, er);
        chk("midreset_keep", rd, 32'h22222222);

        xfer(1, 1, 32'h10, 32'h12345678, lat, rd, er);
        chk("w0_store_lat", lat, 0);
        issue(1, 0, 32'h10, 32'h0, at);
        go = resp_valid[1]; rd = resp_rdata[1];
        lows = 0;
        for (int i = 0; i < 3; i++) begin
            if (!req_ready[1]) lows++;
            @(negedge clock);
        end
        chkb("w0_immediate_resp", go, 1'b1);
        chk("w0_load_rdata", rd, 32'h12345678);
        chk("w0_ready_low", lows, 1);

        req_write[2] = 1; req_addr[2] = 32'h0; req_wdata[2] = bdat[0]; req_valid[2] = 1;
        k = 0; nb = 0; bb = 0;
        for (int i = 0; i < 40 && k < 3; i++) begin
            if (k > 0) begin
                nb++;
                if (busy[2]) bb++;
            end
            go = req_ready[2];
            @(negedge clock);
            if (go) begin
                ea[k] = edges;
                k++;
                if (k < 3) begin
                    req_addr[2] = 32'(4 * k); req_wdata[2] = bdat[k];
                end else req_valid[2] = 0;
            end
        end
        req_valid[2] = 0;
        chk("b2b_count", k, 3);
        chk("b2b_gap1", ea[1] - ea[0], 3);
        chk("b2b_gap2", ea[2] - ea[1], 3);
        chk("b2b_busy_cycles", bb, 4);
        chk("b2b_window", nb, 6);
        wait_resp(2, at, rd, er);
        for (int j = 0; j < 3; j++) begin
            xfer(2, 0, 32'(4 * j), 32'h0, lat, rd, er);
            chk($sformatf("b2b_readback%0d", j), rd, bdat[j]);
        end

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
